data_mem_access_unit: RTL and testbench
=======================================

Name: data_mem_access_unit

Overview:
MEM-stage responder for the load/store control fields that the ID stage generates (mem_read[3:0], mem_write[2:0]). It turns each byte, half or word request into transactions on a word-only main-memory port. Sub-word stores use read-modify-write. Load data is sign- or zero-extended. The unit stalls the pipeline through busy_wait until the access completes.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, CPU and memory data width (fixed 32; parameter kept for documentation)

Ports:
clock  in  1  single clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low; 0 forces idle immediately
mem_read  in  4  [3]=load request; [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
mem_write  in  3  [2]=store request; [1:0]=size (00 SB, 01 SH, 10 SW)
address  in  32  byte address from ALU result
write_data  in  32  store data, right-aligned
read_data  out  32  extended load result; valid in DONE
busy_wait  out  1  pipeline stall; high while a request is outstanding
misaligned  out  1  misaligned-access flag (see Optional Feature)
mm_read  out  1  main-memory read request
mm_write  out  1  main-memory write request
mm_address  out  32  word address, {address[31:2],2'b00}
mm_writedata  out  32  full word to write
mm_readdata  in  32  word returned by memory
mm_ready  in  1  one-cycle completion pulse from memory

Behaviour:
- Reset values (asynchronous): state=IDLE; read_data, mm_address and mm_writedata = 0; mm_read, mm_write and misaligned = 0. busy_wait is 0 because IDLE has no registered request.
- States: IDLE, MM_READ, MM_WRITE, DONE.
- busy_wait = (state==IDLE & (mem_read[3]|mem_write[2])) | state==MM_READ | state==MM_WRITE. It is combinational, so the stall starts in the same cycle the request appears.
- In IDLE:
  - A store goes to MM_WRITE when size=10, otherwise to MM_READ (RMW).
  - A load goes to MM_READ.
  - On that edge, latch address, size/funct3 and write_data.
- Store priority: if mem_read[3] and mem_write[2] are both high, the request is treated as a store.
- In MM_READ: mm_read=1 and mm_address is held. On mm_ready:
  - Load: byte lane = addr[1:0] and half lane = addr[1]. Extract and extend per funct3 into read_data, then go to DONE.
  - RMW store: merge the new byte/half into mm_readdata to form mm_writedata, then go to MM_WRITE.
- In MM_WRITE: mm_write=1. On mm_ready, go to DONE.
- In DONE: busy_wait=0 and read_data is held stable. The pipeline advances on the next edge. Next state is IDLE unconditionally, so the same request is never reissued.
- Latency with zero-wait memory (mm_ready in the first request cycle):
  - LW / SB / SH / LB: request edge, then memory edge(s), then DONE.
  - Load: 3 cycles of stall-free completion, busy_wait high for 2 cycles.
  - Sub-word store: busy_wait high for 3 cycles.
- Within a transaction mm_read and mm_write are never both high, and each stays high until mm_ready.
- mm_ready outside MM_READ/MM_WRITE is ignored.
- Reset mid-transaction: the request is abandoned and the outputs return to reset values. A partially completed RMW never writes.
- read_data keeps its last value except when a load completes.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - The check runs in IDLE. A violation is a half access with addr[0]=1, or a word access with addr[1:0]≠00.
  - On a violation: go directly to DONE with misaligned=1 for that DONE cycle only, read_data=0, and no main-memory request.
- Undefined: misaligned is tied 0. Low address bits are ignored for alignment: half uses addr[1] only, word uses lane 0.

Decomposition:
- Shared encodings include holds:
  - load funct3 codes
  - store size codes
  - state encoding
  - mem_read/mem_write bit positions, so the ID-stage encodings and this block agree.
- One natural sub-module: byte_lane_unit. It is combinational and does both jobs: extract/extend for loads and lane merge for stores. It is verified standalone.

Test Plan:
1. LB at 0x103, memory word 0x80FF_1234 → read_data=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
2. SH 0x0000_ABCD at 0x202, old word 0x1122_3344 → one read at 0x200, then one write of 0xABCD_3344 at 0x200.
3. SW 0xDEAD_BEEF at 0x40 with mm_ready delayed 5 cycles → busy_wait high for 6 cycles, exactly one mm_write, no mm_read.
4. LW at 0x006 with MISALIGN_TRAP_EN → misaligned=1 for one cycle, mm_read/mm_write never asserted, read_data=0.
5. reset driven low during MM_WRITE of an SB → mm_write drops asynchronously; after release the state is IDLE and no write has occurred.
6. LW 0x10 immediately followed by SW 0x14 → one read, then one write. DONE separates them, and no duplicate transaction occurs.

Source files
------------

// File: rtl/data_mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access unit: request bit positions, load funct3 codes,
// store size codes, FSM states and the alignment rule used by the MISALIGN_TRAP_EN option.
package data_mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MM_READ  = 2'd1,
        ST_MM_WRITE = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam int LOAD_REQ_BIT  = 3;
    localparam int STORE_REQ_BIT = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Load funct3[1:0] and store size share the byte/half/word encoding, so one check serves both.
    function automatic logic is_misaligned(input logic [1:0] size_code, input logic [1:0] addr_lo);
        return ((size_code == SIZE_H) && addr_lo[0]) ||
               ((size_code == SIZE_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/data_mem_access_unit_byte_lane_unit.sv
// Combinational lane logic: extracts and extends load data from a memory word, and merges
// store bytes/halves into a memory word for read-modify-write.
module data_mem_access_unit_byte_lane_unit
    import data_mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  lane_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        word_sel;

    assign word_sel = (size != SIZE_B) && (size != SIZE_H);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic byte_hit;
            logic half_hit;
            assign lane_byte[gi] = mem_word[8*gi +: 8];
            assign byte_hit = (size == SIZE_B) && (addr_lo == 2'(gi));
            assign half_hit = (size == SIZE_H) && (addr_lo[1] == 1'(gi / 2));
            assign merged_word[8*gi +: 8] = byte_hit ? store_data[7:0] :
                                            half_hit ? store_data[8*(gi % 2) +: 8] :
                                            word_sel ? store_data[8*gi +: 8] :
                                                       mem_word[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = lane_byte[addr_lo];
    assign sel_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        load_data = mem_word;
        case (funct3)
            F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  load_data = {24'd0, sel_byte};
            F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  load_data = {16'd0, sel_half};
            F3_LW:   load_data = mem_word;
            default: load_data = mem_word;
        endcase
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store responder on a word-only memory port; sub-word stores use RMW.
// Optional alignment trap enabled by defining MISALIGN_TRAP_EN.
module data_mem_access_unit
    import data_mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        mem_read,
    input  logic [2:0]        mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              busy_wait,
    output logic              misaligned,
    output logic              mm_read,
    output logic              mm_write,
    output logic [ADDR_W-1:0] mm_address,
    output logic [DATA_W-1:0] mm_writedata,
    input  logic [DATA_W-1:0] mm_readdata,
    input  logic              mm_ready
);

    state_t            state_reg, state_next;
    logic [2:0]        op_reg;
    logic [1:0]        addr_lo_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              is_store_reg;
    logic [DATA_W-1:0] read_data_reg;
    logic [ADDR_W-1:0] mm_address_reg;
    logic [DATA_W-1:0] mm_writedata_reg;
    logic              misaligned_reg;

    logic              load_req, store_req, any_req, access_viol;
    logic [2:0]        req_code;
    logic [DATA_W-1:0] lane_load_data, lane_merged_word;

    // A simultaneous load and store request is serviced as the store.
    assign store_req = mem_write[STORE_REQ_BIT];
    assign load_req  = mem_read[LOAD_REQ_BIT];
    assign any_req   = store_req | load_req;
    assign req_code  = store_req ? {1'b0, mem_write[1:0]} : mem_read[2:0];

`ifdef MISALIGN_TRAP_EN
    assign access_viol = is_misaligned(req_code[1:0], address[1:0]);
`else
    assign access_viol = 1'b0;
`endif

    data_mem_access_unit_byte_lane_unit u_byte_lane_unit (
        .funct3      (op_reg),
        .size        (op_reg[1:0]),
        .addr_lo     (addr_lo_reg),
        .mem_word    (mm_readdata),
        .store_data  (wdata_reg),
        .load_data   (lane_load_data),
        .merged_word (lane_merged_word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    if (access_viol)
                        state_next = ST_DONE;
                    else if (store_req && (mem_write[1:0] == SIZE_W))
                        state_next = ST_MM_WRITE;
                    else
                        state_next = ST_MM_READ;
                end
            end
            ST_MM_READ: begin
                if (mm_ready)
                    state_next = is_store_reg ? ST_MM_WRITE : ST_DONE;
            end
            ST_MM_WRITE: begin
                if (mm_ready)
                    state_next = ST_DONE;
            end
            // DONE always returns to IDLE so a request still on the inputs is not reissued.
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mm_read   = (state_reg == ST_MM_READ);
        mm_write  = (state_reg == ST_MM_WRITE);
        busy_wait = ((state_reg == ST_IDLE) && any_req) ||
                    (state_reg == ST_MM_READ) || (state_reg == ST_MM_WRITE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_reg           <= 3'd0;
            addr_lo_reg      <= 2'd0;
            wdata_reg        <= '0;
            is_store_reg     <= 1'b0;
            read_data_reg    <= '0;
            mm_address_reg   <= '0;
            mm_writedata_reg <= '0;
            misaligned_reg   <= 1'b0;
        end else begin
            misaligned_reg <= 1'b0;
            if ((state_reg == ST_IDLE) && any_req) begin
                op_reg         <= req_code;
                addr_lo_reg    <= address[1:0];
                wdata_reg      <= write_data;
                is_store_reg   <= store_req;
                mm_address_reg <= {address[ADDR_W-1:2], 2'b00};
                misaligned_reg <= access_viol;
                if (access_viol)
                    read_data_reg <= '0;
                else if (store_req && (mem_write[1:0] == SIZE_W))
                    mm_writedata_reg <= write_data;
            end else if ((state_reg == ST_MM_READ) && mm_ready) begin
                if (is_store_reg)
                    mm_writedata_reg <= lane_merged_word;
                else
                    read_data_reg <= lane_load_data;
            end
        end
    end

    assign read_data    = read_data_reg;
    assign mm_address   = mm_address_reg;
    assign mm_writedata = mm_writedata_reg;
    assign misaligned   = misaligned_reg;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Self-checking bench for data_mem_access_unit: directed cases plus random loads/stores
// against a word-array memory model. Build with +define+MISALIGN_TRAP_EN to exercise the trap.
module tb_data_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        busy_wait;
    logic        misaligned;
    logic        mm_read;
    logic        mm_write;
    logic [31:0] mm_address;
    logic [31:0] mm_writedata;
    logic [31:0] mm_readdata;
    logic        mm_ready;

    int          n_vec = 0;
    int          n_bad = 0;
    int          lat = 0;
    int          wait_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] last_mm_addr = 32'd0;
    logic [31:0] model_rd = 32'd0;
    logic [31:0] mem [0:255];

    data_mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .busy_wait    (busy_wait),
        .misaligned   (misaligned),
        .mm_read      (mm_read),
        .mm_write     (mm_write),
        .mm_address   (mm_address),
        .mm_writedata (mm_writedata),
        .mm_readdata  (mm_readdata),
        .mm_ready     (mm_ready)
    );

    always #5 clock = ~clock;

    // Memory responder: ready pulses after 'lat' wait cycles; garbage data while not ready.
    always @(negedge clock) begin
        if (mm_read && mm_write) both_cnt++;
        if (reset && (mm_read || mm_write)) begin
            if (wait_cnt >= lat) begin
                mm_ready     = 1'b1;
                wait_cnt     = 0;
                last_mm_addr = mm_address;
                if (mm_read) begin
                    mm_readdata = mem[mm_address[9:2]];
                    rd_cnt++;
                end else begin
                    mem[mm_address[9:2]] = mm_writedata;
                    wr_cnt++;
                end
            end else begin
                mm_ready    = 1'b0;
                mm_readdata = $urandom;
                wait_cnt++;
            end
        end else begin
            mm_ready = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] a);
        logic [31:0] b, h;
        b = (w >> (8 * a[1:0])) & 32'h0000_00FF;
        h = (w >> (16 * a[1])) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_store(input logic [31:0] old, input logic [1:0] size,
                                              input logic [31:0] a, input logic [31:0] d);
        int          sh;
        logic [31:0] m;
        case (size)
            2'b00: begin
                sh = 8 * a[1:0];
                m  = 32'h0000_00FF << sh;
                return (old & ~m) | ((d & 32'h0000_00FF) << sh);
            end
            2'b01: begin
                sh = 16 * a[1];
                m  = 32'h0000_FFFF << sh;
                return (old & ~m) | ((d & 32'h0000_FFFF) << sh);
            end
            default: return d;
        endcase
    endfunction

    task automatic do_op(input bit st, input bit both, input logic [2:0] code,
                         input logic [31:0] a, input logic [31:0] d, input int lt,
                         input string tag);
        logic [31:0] old, expw;
        int          idx, eb, er, ew, cyc, r0, w0;
        bit          viol, done;
        idx  = int'(a[9:2]);
        old  = mem[idx];
        viol = 1'b0;
`ifdef MISALIGN_TRAP_EN
        viol = ((code[1:0] == 2'b01) && a[0]) || ((code[1:0] == 2'b10) && (a[1:0] != 2'b00));
`endif
        if (viol) begin
            eb = 1; er = 0; ew = 0; expw = old; model_rd = 32'd0;
        end else if (!st) begin
            eb = 2 + lt; er = 1; ew = 0; expw = old; model_rd = exp_load(old, code, a);
        end else if (code[1:0] == 2'b10) begin
            eb = 2 + lt; er = 0; ew = 1; expw = d;
        end else begin
            eb = 3 + 2 * lt; er = 1; ew = 1; expw = exp_store(old, code[1:0], a, d);
        end
        @(posedge clock); #1;
        lat        = lt;
        r0         = rd_cnt;
        w0         = wr_cnt;
        mem_read   = st ? (both ? {1'b1, 3'($urandom_range(0, 7))} : 4'b0000) : {1'b1, code};
        mem_write  = st ? {1'b1, code[1:0]} : 3'b000;
        address    = a;
        write_data = d;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clock);
            if (busy_wait) cyc++;
            else done = 1'b1;
        end
        chk({tag, ".completed"}, 32'(done), 32'd1);
        chk({tag, ".busy_cycles"}, cyc, eb);
        chk({tag, ".read_data"}, read_data, model_rd);
        chk({tag, ".misaligned"}, 32'(misaligned), 32'(viol));
        chk({tag, ".mm_reads"}, rd_cnt - r0, er);
        chk({tag, ".mm_writes"}, wr_cnt - w0, ew);
        chk({tag, ".mem_word"}, mem[idx], expw);
        if (st && !viol) chk({tag, ".mm_writedata"}, mm_writedata, expw);
        if (er + ew > 0) chk({tag, ".mm_address"}, last_mm_addr, {a[31:2], 2'b00});
        $display("%s st=%0d code=%0d addr=%h wdata=%h lat=%0d busy=%0d read_data=%h",
                 tag, st, code, a, d, lt, cyc, read_data);
    endtask

    task automatic idle_cycle();
        @(posedge clock); #1;
        mem_read  = 4'b0000;
        mem_write = 3'b000;
        @(negedge clock);
        chk("idle.busy_wait", 32'(busy_wait), 32'd0);
    endtask

    initial begin
        logic [31:0] old_w;
        int          w0, k, cyc;
        bit          seen;
        reset       = 1'b0;
        mem_read    = 4'b0000;
        mem_write   = 3'b000;
        address     = 32'd0;
        write_data  = 32'd0;
        mm_ready    = 1'b0;
        mm_readdata = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset.read_data", read_data, 32'd0);
        chk("reset.busy_wait", 32'(busy_wait), 32'd0);
        chk("reset.mm_read", 32'(mm_read), 32'd0);
        chk("reset.mm_write", 32'(mm_write), 32'd0);
        chk("reset.mm_address", mm_address, 32'd0);
        chk("reset.mm_writedata", mm_writedata, 32'd0);
        chk("reset.misaligned", 32'(misaligned), 32'd0);
        @(posedge clock); #1 reset = 1'b1;

        mem[8'h40] = 32'h80FF_1234;
        do_op(1'b0, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 0, "t1_lb");
        do_op(1'b0, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 0, "t1_lbu");
        idle_cycle();
        mem[8'h80] = 32'h1122_3344;
        do_op(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 0, "t2_sh");
        idle_cycle();
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 4, "t3_sw");
        idle_cycle();
        do_op(1'b0, 1'b0, 3'b010, 32'h0000_0006, 32'd0, 0, "t4_lw_unaligned");
        idle_cycle();

        // Reset during the write phase of a byte RMW store.
        old_w = mem[8'hC1];
        w0    = wr_cnt;
        @(posedge clock); #1;
        lat        = 20;
        mem_write  = 3'b100;
        address    = 32'h0000_0305;
        write_data = 32'h0000_005A;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (mm_write) seen = 1'b1;
        end
        chk("t5.reached_write", 32'(seen), 32'd1);
        @(negedge clock); #2 reset = 1'b0;
        #1;
        chk("t5.mm_write_async", 32'(mm_write), 32'd0);
        chk("t5.mm_read_async", 32'(mm_read), 32'd0);
        chk("t5.read_data", read_data, 32'd0);
        chk("t5.mm_writedata", mm_writedata, 32'd0);
        mem_write = 3'b000;
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        chk("t5.idle_busy", 32'(busy_wait), 32'd0);
        chk("t5.idle_mm_write", 32'(mm_write), 32'd0);
        chk("t5.no_write", wr_cnt - w0, 0);
        chk("t5.mem_intact", mem[8'hC1], old_w);
        $display("t5_reset_mid_sb addr=00000305 writes=%0d", wr_cnt - w0);
        model_rd = 32'd0;

        do_op(1'b0, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 0, "t6_lw");
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_0014, 32'h0BAD_F00D, 0, "t6_sw");
        idle_cycle();

        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 7);
            case (k)
                0: do_op(1'b0, 1'b0, 3'b000, $urandom_range(0, 1023), 32'd0, $urandom_range(0, 3), "rnd_lb");
                1: do_op(1'b0, 1'b0, 3'b001, $urandom_range(0, 1023), 32'd0, $urandom_range(0, 3), "rnd_lh");
                2: do_op(1'b0, 1'b0, 3'b010, $urandom_range(0, 1023), 32'd0, $urandom_range(0, 3), "rnd_lw");
                3: do_op(1'b0, 1'b0, 3'b100, $urandom_range(0, 1023), 32'd0, $urandom_range(0, 3), "rnd_lbu");
                4: do_op(1'b0, 1'b0, 3'b101, $urandom_range(0, 1023), 32'd0, $urandom_range(0, 3), "rnd_lhu");
                5: do_op(1'b1, 1'($urandom), 3'b000, $urandom_range(0, 1023), $urandom, $urandom_range(0, 3), "rnd_sb");
                6: do_op(1'b1, 1'($urandom), 3'b001, $urandom_range(0, 1023), $urandom, $urandom_range(0, 3), "rnd_sh");
                default: do_op(1'b1, 1'($urandom), 3'b010, $urandom_range(0, 1023), $urandom, $urandom_range(0, 3), "rnd_sw");
            endcase
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        chk("never_read_and_write", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
